// File: rtl/table_pkg.sv
// Shared types and helpers for the table access arbiter.
package table_pkg;

    // Requester ids are stored zero-extended to this width in the lane tags.
    localparam int unsigned TAG_ID_W = 8;

    typedef enum logic {
        S_ARB,
        S_CLEAR
    } fsm_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } lane_tag_t;

    // Index width for a table/requester count, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/table_rr_lane_alloc.sv
// Round-robin scan of requesters and allocation onto free table lanes.
module table_rr_lane_alloc
    import table_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned IW          = 5,
    parameter int unsigned INPUT_RATE  = 2,
    parameter int unsigned OUTPUT_RATE = 2,
    localparam int unsigned RW         = idx_width(NUM_REQ)
) (
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*IW-1:0]     req_index,
    input  logic [RW-1:0]             rr_ptr,
    output logic [NUM_REQ-1:0]        grant,
    output logic [INPUT_RATE-1:0]     wr_lane_valid,
    output logic [INPUT_RATE*RW-1:0]  wr_lane_id,
    output logic [OUTPUT_RATE-1:0]    rd_lane_valid,
    output logic [OUTPUT_RATE*RW-1:0] rd_lane_id,
    output logic [RW-1:0]             rr_ptr_next
);

    // Writes are allocated first so every read can be checked against all writes of this cycle.
    always_comb begin
        int unsigned wr_cnt;
        int unsigned rd_cnt;
        int unsigned last_pos;
        logic        any;
        logic        hazard;
        grant         = '0;
        wr_lane_valid = '0;
        wr_lane_id    = '0;
        rd_lane_valid = '0;
        rd_lane_id    = '0;
        rr_ptr_next   = rr_ptr;
        wr_cnt        = 0;
        rd_cnt        = 0;
        last_pos      = 0;
        any           = 1'b0;
        hazard        = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == (int'(rr_ptr) + k) % NUM_REQ && en && req_valid[j] && req_we[j] &&
                    wr_cnt < INPUT_RATE) begin
                    hazard = 1'b0;
                    for (int m = 0; m < NUM_REQ; m++) begin
                        if (grant[m] && req_index[m*IW +: IW] == req_index[j*IW +: IW]) begin
                            hazard = 1'b1;
                        end
                    end
                    if (!hazard) begin
                        grant[j] = 1'b1;
                        for (int l = 0; l < INPUT_RATE; l++) begin
                            if (l == wr_cnt) begin
                                wr_lane_valid[l]       = 1'b1;
                                wr_lane_id[l*RW +: RW] = RW'(j);
                            end
                        end
                        wr_cnt++;
                        any = 1'b1;
                        if (k > last_pos) last_pos = k;
                    end
                end
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == (int'(rr_ptr) + k) % NUM_REQ && en && req_valid[j] && !req_we[j] &&
                    rd_cnt < OUTPUT_RATE) begin
                    hazard = 1'b0;
                    for (int m = 0; m < NUM_REQ; m++) begin
                        if (grant[m] && req_we[m] &&
                            req_index[m*IW +: IW] == req_index[j*IW +: IW]) begin
                            hazard = 1'b1;
                        end
                    end
                    if (!hazard) begin
                        grant[j] = 1'b1;
                        for (int l = 0; l < OUTPUT_RATE; l++) begin
                            if (l == rd_cnt) begin
                                rd_lane_valid[l]       = 1'b1;
                                rd_lane_id[l*RW +: RW] = RW'(j);
                            end
                        end
                        rd_cnt++;
                        any = 1'b1;
                        if (k > last_pos) last_pos = k;
                    end
                end
            end
        end
        if (any) rr_ptr_next = RW'((int'(rr_ptr) + last_pos + 1) % NUM_REQ);
    end

endmodule

// File: rtl/table_access_arbiter.sv
// Shares a multi-lane table among requesters; also runs a full-table clear sequence.
module table_access_arbiter
    import table_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TABLE_SIZE  = 32,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned INPUT_RATE  = 2,
    parameter int unsigned OUTPUT_RATE = 2,
    localparam int unsigned IW         = idx_width(TABLE_SIZE)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ-1:0]                req_we,
    input  logic [NUM_REQ*IW-1:0]             req_index,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]     req_wdata,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [NUM_REQ-1:0]                rsp_valid,
    output logic [NUM_REQ*DATA_WIDTH-1:0]     rsp_data,
    input  logic                              clear_start,
    output logic                              clear_busy,
    output logic [INPUT_RATE-1:0]             tbl_wr_en,
    output logic [INPUT_RATE*IW-1:0]          tbl_index_wr,
    output logic [INPUT_RATE*DATA_WIDTH-1:0]  tbl_data_wr,
    output logic                              tbl_rd_en,
    output logic [OUTPUT_RATE*IW-1:0]         tbl_index_rd,
    input  logic [OUTPUT_RATE*DATA_WIDTH-1:0] tbl_data_rd
);

    localparam int unsigned RW = idx_width(NUM_REQ);

    fsm_e                     state_q, state_d;
    logic [RW-1:0]            rr_ptr_q, rr_ptr_d, rr_ptr_next;
    logic [IW-1:0]            cnt_q, cnt_d;
    lane_tag_t                tag_q [OUTPUT_RATE];
    lane_tag_t                tag_d [OUTPUT_RATE];
    logic                     arb_en;
    logic [NUM_REQ-1:0]       grant;
    logic [INPUT_RATE-1:0]    wr_lane_valid;
    logic [INPUT_RATE*RW-1:0] wr_lane_id;
    logic [OUTPUT_RATE-1:0]   rd_lane_valid;
    logic [OUTPUT_RATE*RW-1:0] rd_lane_id;

    // Gating with rst keeps grants and table enables low while reset is asserted.
    assign arb_en     = (state_q == S_ARB) && !rst;
    assign req_ready  = grant;
    assign clear_busy = (state_q == S_CLEAR);
    assign tbl_rd_en  = |rd_lane_valid;

    table_rr_lane_alloc #(
        .NUM_REQ     (NUM_REQ),
        .IW          (IW),
        .INPUT_RATE  (INPUT_RATE),
        .OUTPUT_RATE (OUTPUT_RATE)
    ) u_alloc (
        .en            (arb_en),
        .req_valid     (req_valid),
        .req_we        (req_we),
        .req_index     (req_index),
        .rr_ptr        (rr_ptr_q),
        .grant         (grant),
        .wr_lane_valid (wr_lane_valid),
        .wr_lane_id    (wr_lane_id),
        .rd_lane_valid (rd_lane_valid),
        .rd_lane_id    (rd_lane_id),
        .rr_ptr_next   (rr_ptr_next)
    );

    // FSM, round-robin pointer and clear counter next state.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            S_ARB: begin
                rr_ptr_d = rr_ptr_next;
                if (clear_start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (cnt_q == IW'(TABLE_SIZE - INPUT_RATE)) begin
                    cnt_d   = '0;
                    state_d = S_ARB;
                end else begin
                    cnt_d = cnt_q + IW'(INPUT_RATE);
                end
            end
            default: state_d = S_ARB;
        endcase
    end

    // Each granted read lane remembers its owner for the response one cycle later.
    always_comb begin
        for (int l = 0; l < OUTPUT_RATE; l++) begin
            tag_d[l].valid = rd_lane_valid[l];
            tag_d[l].id    = TAG_ID_W'(rd_lane_id[l*RW +: RW]);
        end
    end

    // Table port drive: clear pattern in S_CLEAR, otherwise the granted requests per lane.
    always_comb begin
        tbl_wr_en    = '0;
        tbl_index_wr = '0;
        tbl_data_wr  = '0;
        tbl_index_rd = '0;
        if (state_q == S_CLEAR) begin
            for (int l = 0; l < INPUT_RATE; l++) begin
                tbl_wr_en[l]            = 1'b1;
                tbl_index_wr[l*IW +: IW] = cnt_q + IW'(l);
            end
        end else begin
            for (int l = 0; l < INPUT_RATE; l++) begin
                for (int r = 0; r < NUM_REQ; r++) begin
                    if (wr_lane_valid[l] && wr_lane_id[l*RW +: RW] == RW'(r)) begin
                        tbl_wr_en[l]                            = 1'b1;
                        tbl_index_wr[l*IW +: IW]                = req_index[r*IW +: IW];
                        tbl_data_wr[l*DATA_WIDTH +: DATA_WIDTH] =
                            req_wdata[r*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
        for (int l = 0; l < OUTPUT_RATE; l++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (rd_lane_valid[l] && rd_lane_id[l*RW +: RW] == RW'(r)) begin
                    tbl_index_rd[l*IW +: IW] = req_index[r*IW +: IW];
                end
            end
        end
    end

    // Route each tagged read lane back to its owning requester.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int l = 0; l < OUTPUT_RATE; l++) begin
            for (int r = 0; r < NUM_REQ; r++) begin
                if (tag_q[l].valid && tag_q[l].id == TAG_ID_W'(r)) begin
                    rsp_valid[r]                         = 1'b1;
                    rsp_data[r*DATA_WIDTH +: DATA_WIDTH] =
                        tbl_data_rd[l*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // State registers; reset abandons any clear and drops pending responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_ARB;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int l = 0; l < OUTPUT_RATE; l++) tag_q[l] <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            for (int l = 0; l < OUTPUT_RATE; l++) tag_q[l] <= tag_d[l];
        end
    end

endmodule

// File: tb/tb_table_access_arbiter.sv
// Directed bench for table_access_arbiter with a behavioural table and a response scoreboard.
module tb_table_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
    logic [19:0] req_index;
    logic [31:0] req_wdata, rsp_data;
    logic        clear_start, clear_busy;
    logic [1:0]  tbl_wr_en;
    logic [9:0]  tbl_index_wr, tbl_index_rd;
    logic [15:0] tbl_data_wr, tbl_data_rd;
    logic        tbl_rd_en;

    table_access_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_index    (req_index),
        .req_wdata    (req_wdata),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .clear_start  (clear_start),
        .clear_busy   (clear_busy),
        .tbl_wr_en    (tbl_wr_en),
        .tbl_index_wr (tbl_index_wr),
        .tbl_data_wr  (tbl_data_wr),
        .tbl_rd_en    (tbl_rd_en),
        .tbl_index_rd (tbl_index_rd),
        .tbl_data_rd  (tbl_data_rd)
    );

    always #5 clk = ~clk;

    // Behavioural table: two write lanes, two registered read lanes.
    logic [7:0]  mem [32];
    logic [15:0] rd_q;
    logic        mem_init;
    assign tbl_data_rd = rd_q;
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            rd_q <= 16'h0;
        end else begin
            for (int l = 0; l < 2; l++)
                if (tbl_wr_en[l]) mem[tbl_index_wr[l*5 +: 5]] <= tbl_data_wr[l*8 +: 8];
            if (tbl_rd_en)
                for (int l = 0; l < 2; l++) rd_q[l*8 +: 8] <= mem[tbl_index_rd[l*5 +: 5]];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t       sb[$];
    logic [7:0] ref_mem [32];
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input bit v, input bit we, input int idx, input int d);
        req_valid[r]         = v;
        req_we[r]            = we;
        req_index[r*5 +: 5]  = 5'(idx);
        req_wdata[r*8 +: 8]  = 8'(d);
    endtask

    task automatic wr(input int r, input int idx, input int d);
        set_req(r, 1'b1, 1'b1, idx, d);
    endtask

    task automatic rd(input int r, input int idx);
        set_req(r, 1'b1, 1'b0, idx, 0);
    endtask

    task automatic drop(input int r);
        req_valid[r] = 1'b0;
    endtask

    // Called in the grant cycle: the response is due in the very next cycle.
    task automatic expect_rd(input int r, input int idx);
        sb.push_back('{id: r, data: ref_mem[idx], cyc: cyc + 1});
    endtask

    // Response monitor: every rsp_valid pulse must match a queued expectation.
    always @(negedge clk) begin
        int hit;
        if (!rst) begin
            for (int r = 0; r < 4; r++) begin
                if (rsp_valid[r]) begin
                    hit = -1;
                    for (int i = 0; i < sb.size(); i++)
                        if (hit < 0 && sb[i].id == r) hit = i;
                    if (hit < 0) begin
                        chk($sformatf("rsp%0d_unexpected", r), 32'(rsp_valid[r]), 32'd0);
                    end else begin
                        chk($sformatf("rsp%0d_data", r), 32'(rsp_data[r*8 +: 8]),
                            32'(sb[hit].data));
                        chk($sformatf("rsp%0d_latency", r), cyc, sb[hit].cyc);
                        sb.delete(hit);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        rst = 1'b1; mem_init = 1'b1; clear_start = 1'b0;
        req_valid = 4'hF; req_we = 4'hF; req_index = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_wr_en", 32'(tbl_wr_en), 32'h0);
        chk("rst_rd_en", 32'(tbl_rd_en), 32'h0);
        chk("rst_busy", 32'(clear_busy), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        mem_init = 1'b0; rst = 1'b0; req_valid = 4'h0; req_we = 4'h0;
        tick();

        // single requester write then read
        wr(0, 5, 'hA5); #1;
        chk("w5_ready", 32'(req_ready), 32'b0001);
        chk("w5_wr_en", 32'(tbl_wr_en), 32'b01);
        chk("w5_idx", 32'(tbl_index_wr[4:0]), 32'd5);
        chk("w5_data", 32'(tbl_data_wr[7:0]), 32'hA5);
        ref_mem[5] = 8'hA5;
        tick();
        rd(0, 5); #1;
        chk("r5_ready", 32'(req_ready), 32'b0001);
        chk("r5_rd_en", 32'(tbl_rd_en), 32'd1);
        chk("r5_idx", 32'(tbl_index_rd[4:0]), 32'd5);
        expect_rd(0, 5);
        tick();
        drop(0); rd(3, 0); #1;
        chk("r0_ready", 32'(req_ready), 32'b1000);
        expect_rd(3, 0);
        tick(); drop(3);

        // four writes from pointer 0: two per cycle in round-robin order
        for (int r = 0; r < 4; r++) wr(r, 10 + r, 'h10 + r);
        #1;
        chk("rr4_c1_ready", 32'(req_ready), 32'b0011);
        ref_mem[10] = 8'h10; ref_mem[11] = 8'h11;
        tick();
        drop(1); wr(0, 14, 'h14); #1;
        chk("rr4_c2_ready", 32'(req_ready), 32'b1100);
        ref_mem[12] = 8'h12; ref_mem[13] = 8'h13;
        tick();
        drop(2); drop(3); #1;
        chk("rr4_c3_ready", 32'(req_ready), 32'b0001);
        ref_mem[14] = 8'h14;
        tick(); drop(0);
        rd(3, 10); #1;
        chk("r10_ready", 32'(req_ready), 32'b1000);
        expect_rd(3, 10);
        tick(); drop(3);

        // two writes to the same index: earlier-scanned wins
        wr(0, 7, 'h11); wr(1, 7, 'h22); #1;
        chk("ww7_c1_ready", 32'(req_ready), 32'b0001);
        chk("ww7_c1_wr_en", 32'(tbl_wr_en), 32'b01);
        chk("ww7_c1_data", 32'(tbl_data_wr[7:0]), 32'h11);
        tick();
        drop(0); #1;
        chk("ww7_c2_ready", 32'(req_ready), 32'b0010);
        chk("ww7_c2_data", 32'(tbl_data_wr[7:0]), 32'h22);
        ref_mem[7] = 8'h22;
        tick(); drop(1);
        rd(2, 7); #1;
        chk("r7_ready", 32'(req_ready), 32'b0100);
        expect_rd(2, 7);
        tick(); drop(2);

        // read of an index being written is held one cycle
        wr(0, 3, 'h3C); rd(1, 3); #1;
        chk("wr3_c1_ready", 32'(req_ready), 32'b0001);
        chk("wr3_c1_rd_en", 32'(tbl_rd_en), 32'd0);
        ref_mem[3] = 8'h3C;
        tick();
        drop(0); #1;
        chk("wr3_c2_ready", 32'(req_ready), 32'b0010);
        expect_rd(1, 3);
        tick(); drop(1);

        // mixed: two reads and two writes in one cycle (pointer is 2)
        rd(0, 10); wr(1, 20, 'h55); rd(2, 11); wr(3, 21, 'h66); #1;
        chk("mix_ready", 32'(req_ready), 32'b1111);
        chk("mix_rd_en", 32'(tbl_rd_en), 32'd1);
        chk("mix_idx_rd", 32'(tbl_index_rd), 32'({5'd10, 5'd11}));
        chk("mix_wr_en", 32'(tbl_wr_en), 32'b11);
        chk("mix_idx_wr", 32'(tbl_index_wr), 32'({5'd20, 5'd21}));
        chk("mix_data_wr", 32'(tbl_data_wr), 32'h5566);
        expect_rd(2, 11); expect_rd(0, 10);
        ref_mem[20] = 8'h55; ref_mem[21] = 8'h66;
        tick();
        req_valid = 4'h0;

        // fill the whole table
        for (int i = 0; i < 16; i++) begin
            wr(0, 2 * i, (2 * i) ^ 'hC3); wr(1, 2 * i + 1, (2 * i + 1) ^ 'hC3); #1;
            chk($sformatf("fill%0d_ready", i), 32'(req_ready), 32'b0011);
            ref_mem[2 * i]     = 8'(2 * i) ^ 8'hC3;
            ref_mem[2 * i + 1] = 8'(2 * i + 1) ^ 8'hC3;
            tick();
        end
        drop(0); drop(1);

        // clear_start cycle still arbitrates; its read is delivered
        rd(2, 4); clear_start = 1'b1; #1;
        chk("clr_start_ready", 32'(req_ready), 32'b0100);
        chk("clr_start_busy", 32'(clear_busy), 32'd0);
        expect_rd(2, 4);
        tick();
        clear_start = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;
        for (int k = 0; k < 16; k++) begin
            if (k == 3) clear_start = 1'b1;
            if (k == 4) clear_start = 1'b0;
            #1;
            chk($sformatf("clr%0d_busy", k), 32'(clear_busy), 32'd1);
            chk($sformatf("clr%0d_ready", k), 32'(req_ready), 32'd0);
            chk($sformatf("clr%0d_wr_en", k), 32'(tbl_wr_en), 32'b11);
            chk($sformatf("clr%0d_idx", k), 32'(tbl_index_wr),
                32'({5'(2 * k + 1), 5'(2 * k)}));
            chk($sformatf("clr%0d_data", k), 32'(tbl_data_wr), 32'h0);
            tick();
        end
        #1;
        chk("clr_done_busy", 32'(clear_busy), 32'd0);
        chk("clr_done_ready", 32'(req_ready), 32'b0100);
        expect_rd(2, 4);
        tick(); drop(2);
        rd(3, 7); rd(0, 21); #1;
        chk("post_clr_ready", 32'(req_ready), 32'b1001);
        expect_rd(3, 7); expect_rd(0, 21);
        tick(); drop(3); drop(0);

        // reset in cycle 8 of a clear
        clear_start = 1'b1; #1;
        tick();
        clear_start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk($sformatf("rclr%0d_busy", k), 32'(clear_busy), 32'd1);
            tick();
        end
        rd(0, 30); rst = 1'b1; #1;
        chk("rclr_rst_busy", 32'(clear_busy), 32'd0);
        chk("rclr_rst_ready", 32'(req_ready), 32'd0);
        chk("rclr_rst_wr_en", 32'(tbl_wr_en), 32'd0);
        tick();
        rst = 1'b0; #1;
        chk("rclr_after_ready", 32'(req_ready), 32'b0001);
        chk("rclr_after_busy", 32'(clear_busy), 32'd0);
        expect_rd(0, 30);
        tick(); drop(0);

        // a fresh clear starts again from index 0 and lasts 16 cycles
        clear_start = 1'b1; #1;
        tick();
        clear_start = 1'b0; #1;
        chk("clr2_first_busy", 32'(clear_busy), 32'd1);
        chk("clr2_first_idx", 32'(tbl_index_wr), 32'({5'd1, 5'd0}));
        repeat (15) tick();
        chk("clr2_last_busy", 32'(clear_busy), 32'd1);
        chk("clr2_last_idx", 32'(tbl_index_wr), 32'({5'd31, 5'd30}));
        tick();
        chk("clr2_done_busy", 32'(clear_busy), 32'd0);

        // reset between grant and response drops the response
        rd(3, 0); #1;
        chk("rdrop_ready", 32'(req_ready), 32'b1000);
        tick();
        rst = 1'b1; #1;
        chk("rdrop_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        rst = 1'b0; drop(3);
        tick(); tick();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
